beta_fetch_unit: RTL and testbench
==================================

# beta_fetch_unit

Instruction fetch unit of the beta core. It holds the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Responses are buffered in a small in-order queue that feeds the decode stage. It consumes the BJU's next-PC output as a redirect: all in-flight and buffered instructions are flushed and fetch restarts at the target.

## Interface
- `DataWidth`, default 32: width of instruction/data lines.
- `AddrWidth`, default 32: width of PC and memory addresses.
- `BootAddr`, default 32'h0000_0000: PC value after reset; bits [1:0] must be 00.
- `FifoDepth`, default 3: entries in the fetch queue; must be ≥2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `fetch_en_i`  in  1  allows new requests when high; does not block responses or pops.
- `redirect_i`  in  1  BJU redirect strobe; one cycle per redirect.
- `redirect_pc_i`  in  AddrWidth  redirect target. Bits [1:0] are ignored and treated as 00.
- `imem_req_o`  out  1  memory request valid.
- `imem_addr_o`  out  AddrWidth  request word address.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response valid. Responses return in request order, ≥1 cycle after grant.
- `imem_rdata_i`  in  DataWidth  response instruction.
- `ifu_valid_o`  out  1  head entry holds a valid instruction.
- `ifu_instr_o`  out  DataWidth  head instruction.
- `ifu_pc_o`  out  AddrWidth  PC of the head instruction.
- `ifu_ready_i`  in  1  decode accepts the head entry (pop when valid & ready).
- `ifu_busy_o`  out  1  high while any request is outstanding or any discard is pending.

## Operation
- **Fetch PC (`fpc`):**
  - Reset value is `BootAddr`.
  - On a grant without redirect, `fpc <= fpc + 4`. Addition wraps modulo 2^AddrWidth.
  - On redirect, `fpc <= {redirect_pc_i[AddrWidth-1:2], 2'b00}`.
- **Queue slots:**
  - A slot is allocated at grant and stores `fpc`.
  - The same slot is filled at the matching rvalid and stores `imem_rdata_i`.
  - Allocation order equals response order.
- **Request issue:** `imem_req_o` is high when either condition holds:
  - a request is pending and not yet granted, or
  - `fetch_en_i` is high and (allocated − pop_this_cycle) < FifoDepth.
- **Request stability:** once raised, `imem_req_o` and `imem_addr_o` stay stable until `imem_gnt_i`. `fetch_en_i` falling or `redirect_i` does not withdraw a pending request.
- **Queue output:** `ifu_valid_o = head_allocated & head_filled & ~redirect_i`. `ifu_instr_o` and `ifu_pc_o` come from the head slot. Their value is don't-care when not valid.
- **Flush on redirect:**
  - All slots are freed.
  - `discard_cnt` takes the number of granted-but-not-returned requests, including a grant in the same cycle.
  - A pending ungranted request whose grant arrives later also increments `discard_cnt` at that grant and does not advance `fpc`.
- **Discards:** each rvalid while `discard_cnt > 0` is dropped and decrements the counter. `discard_cnt` width is `$clog2(FifoDepth+2)`. It never exceeds FifoDepth+1.
- **Simultaneous events:**
  - Redirect together with pop: flush wins and the pop is ignored.
  - Redirect together with rvalid: the response counts as outstanding-at-redirect and is dropped.
  - Grant and rvalid in the same cycle: allocate and fill occur independently.
  - Pop and allocate in the same cycle: net occupancy is unchanged.
- **Reset mid-operation:** state clears immediately. Responses arriving after reset deassertion for pre-reset requests are the memory's responsibility and must not occur.

## Timing
- **Reset values:**
  - `imem_req_o` = 0, `imem_addr_o` = BootAddr.
  - `ifu_valid_o` = 0, `ifu_instr_o` = 0, `ifu_pc_o` = 0.
  - `ifu_busy_o` = 0, `discard_cnt` = 0, queue empty.
- **First request:** `imem_req_o` rises in the first cycle after reset release with `fetch_en_i` high.
- **Fill latency:** the instruction is visible on `ifu_valid_o` the cycle after its rvalid (registered fill).
- **Throughput:** with single-cycle grant and 1-cycle rvalid and FifoDepth=3, one instruction per cycle is sustained.
- **Redirect at cycle N, no pending ungranted request:** `imem_req_o` with the target address at N+1 (if `fetch_en_i` is high). The first target instruction is valid no earlier than N+3.
- **Combinational paths:**
  - `redirect_i` → `ifu_valid_o` only.
  - `ifu_ready_i` → `imem_req_o` via the credit check.

## Structure
- **beta_pkg additions:**
  - `ifu_entry_t` (pc, instr, filled).
  - `IFU_BOOT_ADDR` constant, default source for `BootAddr`.
- **Sub-module `beta_ifu_queue`:**
  - Circular buffer with alloc/fill/pop/flush ports; pointers and count sized `$clog2(FifoDepth)+1`.
  - The top level holds `fpc`, request control and `discard_cnt`.

## Test plan
- Reset, `fetch_en_i`=1, memory with always-gnt and 1-cycle rvalid → addresses 0x0, 0x4, 0x8… on consecutive cycles; `ifu_pc_o` matches, one valid per cycle with `ifu_ready_i`=1.
- `ifu_ready_i`=0 for 10 cycles → exactly 3 slots allocated, `imem_req_o` low afterwards. Releasing ready resumes in order with no loss or duplication.
- Redirect to 0x100 with two responses outstanding → those two rvalids are dropped and the next valid instruction has PC 0x100.
- `imem_gnt_i` withheld for 4 cycles while redirect to 0x200 fires → `imem_addr_o` stays stable until granted, that response is discarded, and the next request is 0x200.
- Redirect in the same cycle as a pop, a grant and an rvalid → no instruction consumed, `fpc` = target, `discard_cnt` correct, no stale instruction reaches decode.
- `fpc` = 0xFFFF_FFFC granted → next address 0x0000_0000. `redirect_pc_i` = 0x103 → fetch from 0x100.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core front end.
package beta_pkg;

  localparam int unsigned IFU_XLEN = 32;
  localparam logic [IFU_XLEN-1:0] IFU_BOOT_ADDR = 32'h0000_0000;

  // One fetch-queue slot: allocated at grant with its PC, filled at rvalid.
  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] instr;
    logic                filled;
  } ifu_entry_t;

  // Circular-buffer pointer increment for depths that need not be powers of two.
  function automatic int unsigned ifu_ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/beta_fetch_unit_queue.sv
// In-order fetch queue: slots are allocated with a PC at grant and filled
// with the instruction at the matching response; the head feeds decode.
module beta_ifu_queue
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth     = 3,
  localparam int unsigned PtrW     = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 alloc_i,
  input  logic [AddrWidth-1:0] alloc_pc_i,
  input  logic                 fill_i,
  input  logic [DataWidth-1:0] fill_data_i,
  input  logic                 pop_i,
  output logic [PtrW-1:0]      count_o,
  output logic                 head_valid_o,
  output logic [AddrWidth-1:0] head_pc_o,
  output logic [DataWidth-1:0] head_instr_o
);

  logic [Depth-1:0][AddrWidth-1:0] pc_q;
  logic [Depth-1:0][DataWidth-1:0] instr_q;
  logic [Depth-1:0]                filled_q;
  logic [PtrW-1:0]                 head_q, tail_q, fill_q, cnt_q;
  logic                            head_filled;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      instr_q  <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      // Every outstanding response becomes a discard, so filling restarts at slot 0.
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (alloc_i) tail_q <= PtrW'(ifu_ptr_inc(32'(tail_q), Depth));
      if (fill_i)  fill_q <= PtrW'(ifu_ptr_inc(32'(fill_q), Depth));
      if (pop_i)   head_q <= PtrW'(ifu_ptr_inc(32'(head_q), Depth));
      cnt_q <= cnt_q + PtrW'(alloc_i) - PtrW'(pop_i);
      for (int i = 0; i < Depth; i++) begin
        if (pop_i && head_q == PtrW'(i)) filled_q[i] <= 1'b0;
        if (alloc_i && tail_q == PtrW'(i)) begin
          pc_q[i]     <= alloc_pc_i;
          filled_q[i] <= 1'b0;
        end
        if (fill_i && fill_q == PtrW'(i)) begin
          instr_q[i]  <= fill_data_i;
          filled_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    head_pc_o    = '0;
    head_instr_o = '0;
    head_filled  = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (head_q == PtrW'(i)) begin
        head_pc_o    = pc_q[i];
        head_instr_o = instr_q[i];
        head_filled  = filled_q[i];
      end
    end
  end

  assign head_valid_o = (cnt_q != '0) & head_filled;
  assign count_o      = cnt_q;

endmodule

// File: rtl/beta_fetch_unit.sv
// Beta instruction fetch unit: fetch PC, req/gnt/rvalid request control,
// redirect flush with response discarding, and the decode-facing queue.
module beta_fetch_unit
  import beta_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BootAddr  = AddrWidth'(IFU_BOOT_ADDR),
  parameter int unsigned          FifoDepth = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_en_i,
  input  logic                 redirect_i,
  input  logic [AddrWidth-1:0] redirect_pc_i,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic                 ifu_valid_o,
  output logic [DataWidth-1:0] ifu_instr_o,
  output logic [AddrWidth-1:0] ifu_pc_o,
  input  logic                 ifu_ready_i,
  output logic                 ifu_busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth) + 1;
  localparam int unsigned DcW  = $clog2(FifoDepth + 2);
  localparam int unsigned OsW  = $clog2(2 * FifoDepth + 4);

  logic [AddrWidth-1:0] fpc_q, fpc_d, req_addr_q, redir_pc;
  logic                 req_pend_q, req_pend_d, stale_q, stale_d;
  logic [DcW-1:0]       dcnt_q, dcnt_d;
  logic [OsW-1:0]       outs_q, outs_d;
  logic [PtrW-1:0]      q_cnt;
  logic                 head_vld, credit_ok, gnt, rsp_drop, alloc, fill, pop;

  assign redir_pc = {redirect_pc_i[AddrWidth-1:2], 2'b00};

  // Credit uses the ungated pop so redirect has no path to the request.
  assign credit_ok   = (q_cnt - PtrW'(head_vld & ifu_ready_i)) < PtrW'(FifoDepth);
  assign imem_req_o  = req_pend_q | (fetch_en_i & credit_ok);
  assign imem_addr_o = req_pend_q ? req_addr_q : fpc_q;

  assign gnt      = imem_req_o & imem_gnt_i;
  assign rsp_drop = imem_rvalid_i & (dcnt_q != '0);
  assign alloc    = gnt & ~stale_q & ~redirect_i;
  assign fill     = imem_rvalid_i & (dcnt_q == '0) & ~redirect_i;
  assign pop      = ifu_valid_o & ifu_ready_i;

  assign ifu_valid_o = head_vld & ~redirect_i;
  assign ifu_busy_o  = req_pend_q | (outs_q != '0) | (dcnt_q != '0);

  always_comb begin
    fpc_d      = fpc_q;
    outs_d     = outs_q + OsW'(gnt) - OsW'(imem_rvalid_i);
    dcnt_d     = dcnt_q;
    req_pend_d = imem_req_o & ~imem_gnt_i;
    // A held request that predates a redirect is fetched but thrown away.
    stale_d    = imem_req_o & ~imem_gnt_i & (stale_q | redirect_i);
    if (redirect_i) begin
      fpc_d  = redir_pc;
      dcnt_d = DcW'(outs_d);
    end else begin
      if (alloc) fpc_d = fpc_q + AddrWidth'(4);
      dcnt_d = dcnt_q + DcW'(gnt & stale_q) - DcW'(rsp_drop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fpc_q      <= BootAddr;
      req_addr_q <= BootAddr;
      req_pend_q <= 1'b0;
      stale_q    <= 1'b0;
      dcnt_q     <= '0;
      outs_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      req_addr_q <= imem_addr_o;
      req_pend_q <= req_pend_d;
      stale_q    <= stale_d;
      dcnt_q     <= dcnt_d;
      outs_q     <= outs_d;
    end
  end

  beta_ifu_queue #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .Depth     (FifoDepth)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .alloc_i      (alloc),
    .alloc_pc_i   (imem_addr_o),
    .fill_i       (fill),
    .fill_data_i  (imem_rdata_i),
    .pop_i        (pop),
    .count_o      (q_cnt),
    .head_valid_o (head_vld),
    .head_pc_o    (ifu_pc_o),
    .head_instr_o (ifu_instr_o)
  );

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed and randomized bench for beta_fetch_unit against an in-order
// instruction-stream model and a latency-randomized memory.
module tb_beta_fetch_unit;

  localparam int AW = 32, DW = 32, DEPTH = 3;

  logic          clk = 1'b0, rst;
  logic          fetch_en_i, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [AW-1:0] redirect_pc_i, imem_addr_o, ifu_pc_o;
  logic [DW-1:0] imem_rdata_i, ifu_instr_o;
  logic          ifu_valid_o, ifu_ready_i, ifu_busy_o;

  beta_fetch_unit #(.DataWidth(DW), .AddrWidth(AW), .BootAddr(32'h0), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ifu_valid_o(ifu_valid_o), .ifu_instr_o(ifu_instr_o), .ifu_pc_o(ifu_pc_o),
    .ifu_ready_i(ifu_ready_i), .ifu_busy_o(ifu_busy_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_bad = 0, cyc = 0, pops = 0, grants = 0, p0;
  int unsigned   gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  logic [AW-1:0] exp_pc = '0, pend_addr = '0, a0;
  logic          pend = 1'b0;
  logic          o_req, o_gnt, o_rv, o_valid;
  logic [AW-1:0] o_addr, o_pc;

  function automatic logic [DW-1:0] ins_of(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: memory responds, grants are decided, outputs are checked
  // against the stream model, then the edge is taken.
  task automatic step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ins_of(mq_addr[0]);
    end
    #1;
    imem_gnt_i = imem_req_o && ($urandom_range(99) < gnt_pct);
    #1;
    o_req = imem_req_o; o_addr = imem_addr_o; o_gnt = imem_gnt_i;
    o_rv = imem_rvalid_i; o_valid = ifu_valid_o; o_pc = ifu_pc_o;
    if (pend) begin
      chk("req_held", 32'(imem_req_o), 1);
      chk("addr_held", imem_addr_o, pend_addr);
    end
    if (redirect_i) chk("valid_masked", 32'(ifu_valid_o), 0);
    if (ifu_valid_o && ifu_ready_i) begin
      chk("pop_pc", ifu_pc_o, exp_pc);
      chk("pop_instr", ifu_instr_o, ins_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_i) exp_pc = {redirect_pc_i[AW-1:2], 2'b00};
    if (imem_rvalid_i) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_gnt_i) begin
      mq_addr.push_back(imem_addr_o);
      mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      grants++;
    end
    pend      = imem_req_o && !imem_gnt_i;
    pend_addr = imem_addr_o;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  task automatic wait_pop(input string tag, input logic [AW-1:0] pc);
    int p = pops;
    for (int t = 0; t < 40 && pops == p; t++) step();
    chk({tag, "_seen"}, 32'(pops != p), 1);
    chk(tag, o_pc, pc);
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    redirect_pc_i = pc;
    redirect_i    = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; ifu_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", 32'(ifu_valid_o), 0);
    chk("rst_instr", ifu_instr_o, 0);
    chk("rst_pc", ifu_pc_o, 0);
    chk("rst_busy", 32'(ifu_busy_o), 0);
    rst = 1'b0;
    step();
    chk("idle_no_req", 32'(o_req), 0);

    // Streaming: back-to-back addresses, one instruction per cycle.
    fetch_en_i = 1'b1; ifu_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("seq_req", 32'(o_req), 1);
      chk("seq_addr", o_addr, 32'(4 * k));
      if (k >= 2) chk("seq_valid", 32'(o_valid), 1);
    end

    // Decode stall: the queue fills to depth and requests stop.
    ifu_ready_i = 1'b0;
    repeat (10) step();
    chk("stall_req_low", 32'(o_req), 0);
    chk("stall_alloc", 32'(grants - pops), DEPTH);
    chk("stall_head_valid", 32'(o_valid), 1);
    ifu_ready_i = 1'b1;
    p0 = pops;
    repeat (10) step();
    chk("resume_pops", 32'(pops - p0 >= 8), 1);

    // Redirect with responses still in flight.
    lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    chk("two_outstanding", 32'(mq_addr.size() >= 2), 1);
    redirect_to(32'h100);
    wait_pop("redir100_pop", 32'h100);

    // Grant withheld across a redirect: held address, then discarded.
    lat_lo = 1; lat_hi = 1;
    repeat (4) step();
    gnt_pct = 0;
    step();
    chk("hold_req", 32'(o_req), 1);
    a0 = o_addr;
    step();
    redirect_to(32'h200);
    step();
    chk("hold_addr", o_addr, a0);
    gnt_pct = 100;
    step();
    chk("late_gnt_addr", o_addr, a0);
    chk("late_gnt", 32'(o_gnt), 1);
    step();
    chk("post_redir_addr", o_addr, 32'h200);
    wait_pop("redir200_pop", 32'h200);

    // Redirect coinciding with pop, grant and rvalid.
    repeat (5) step();
    redirect_to(32'h300);
    chk("co_gnt", 32'(o_gnt), 1);
    chk("co_rvalid", 32'(o_rv), 1);
    step();
    chk("co_n1_addr", o_addr, 32'h300);
    chk("co_n1_valid", 32'(o_valid), 0);
    step();
    chk("co_n2_addr", o_addr, 32'h304);
    chk("co_n2_valid", 32'(o_valid), 0);
    step();
    chk("co_n3_valid", 32'(o_valid), 1);
    chk("co_n3_pc", o_pc, 32'h300);

    // Address wrap and unaligned redirect target.
    redirect_to(32'hFFFF_FFFC);
    step();
    chk("wrap_addr0", o_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", o_addr, 32'h0);
    wait_pop("wrap_pop0", 32'hFFFF_FFFC);
    wait_pop("wrap_pop1", 32'h0);
    redirect_to(32'h103);
    step();
    chk("unalign_addr", o_addr, 32'h100);
    wait_pop("unalign_pop", 32'h100);

    // Randomized traffic; the model checks every popped instruction.
    gnt_pct = 60; lat_lo = 1; lat_hi = 3;
    p0 = pops;
    for (int k = 0; k < 800; k++) begin
      fetch_en_i  = ($urandom_range(9) != 0);
      ifu_ready_i = ($urandom_range(9) < 7);
      if ($urandom_range(19) == 0 && mq_addr.size() <= DEPTH) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom();
      end
      step();
    end
    chk("rand_progress", 32'(pops - p0 > 100), 1);

    // Drain to idle.
    fetch_en_i = 1'b0; ifu_ready_i = 1'b1; gnt_pct = 100;
    for (int t = 0; t < 60 && (mq_addr.size() != 0 || ifu_busy_o || ifu_valid_o); t++) step();
    chk("drain_busy", 32'(ifu_busy_o), 0);
    chk("drain_valid", 32'(ifu_valid_o), 0);
    chk("drain_mem", 32'(mq_addr.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
